// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : In-order store queue between the memory execute pipe and the
//               data-cache write port. Stores are held speculatively until
//               the commit stage retires them, then drain one per handshake.
//               A flush drops only the not-yet-committed stores.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               flush                 - drop all uncommitted entries
//               st_valid/st_ready     - store enqueue handshake
//               st_addr/wstrb/wdata   - store payload
//               commit_store1/2_valid - retire one or two oldest uncommitted
//               ld_addr/ld_conflict   - word-address hazard check for a load
//               data_req/addr_ok      - data-cache write handshake
//               data_addr/wstrb/wdata - head entry payload (0 when idle)
//               sb_empty              - no valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
   parameter int SB_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [3:0]  st_wstrb,
   input  logic [31:0] st_wdata,
   input  logic        commit_store1_valid,
   input  logic        commit_store2_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_conflict,
   output logic        data_req,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   output logic        sb_empty
);

   localparam int c_IDX_W = $clog2(SB_DEPTH);
   localparam int c_PTR_W = c_IDX_W + 1;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [c_PTR_W-1:0] r_head;
   logic [c_PTR_W-1:0] r_cmt;
   logic [c_PTR_W-1:0] r_tail;

   logic [31:0] r_addr_mem  [SB_DEPTH];
   logic [3:0]  r_wstrb_mem [SB_DEPTH];
   logic [31:0] r_wdata_mem [SB_DEPTH];

   logic [c_PTR_W-1:0] w_count;
   logic [1:0]         w_ncmt;
   logic [c_PTR_W-1:0] w_cmt_next;
   logic               w_enq;
   logic               w_drain;
   logic [SB_DEPTH-1:0] w_hit;

   assign w_count  = r_tail - r_head;
   assign st_ready = (w_count < c_PTR_W'(SB_DEPTH));
   assign sb_empty = (r_tail == r_head);
   assign data_req = (r_cmt != r_head);

   assign w_ncmt     = {1'b0, commit_store1_valid} + {1'b0, commit_store2_valid};
   assign w_cmt_next = r_cmt + c_PTR_W'(w_ncmt);
   assign w_enq      = st_valid && st_ready && !flush;
   assign w_drain    = data_req && data_addr_ok;

   // Each pointer moves from its own pre-edge value, so enqueue, commit,
   // drain and flush compose freely in a single cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head <= '0;
         r_cmt  <= '0;
         r_tail <= '0;
      end else begin
         r_head <= r_head + c_PTR_W'(w_drain);
         r_cmt  <= w_cmt_next;
         // Flush rewinds tail onto the commit point, honouring this cycle's
         // commits; the flush-cycle enqueue is already suppressed in w_enq.
         if (flush) begin
            r_tail <= w_cmt_next;
         end else begin
            r_tail <= r_tail + c_PTR_W'(w_enq);
         end
      end
   end

   // Entry storage is intentionally not reset; validity comes from pointers.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_addr_mem [r_tail[c_IDX_W-1:0]] <= st_addr;
         r_wstrb_mem[r_tail[c_IDX_W-1:0]] <= st_wstrb;
         r_wdata_mem[r_tail[c_IDX_W-1:0]] <= st_wdata;
      end
   end

   // Gate payload so undefined storage never leaks out while idle.
   assign data_addr  = data_req ? r_addr_mem [r_head[c_IDX_W-1:0]] : 32'h0;
   assign data_wstrb = data_req ? r_wstrb_mem[r_head[c_IDX_W-1:0]] : 4'h0;
   assign data_wdata = data_req ? r_wdata_mem[r_head[c_IDX_W-1:0]] : 32'h0;

   // A slot is live when its distance from head is below the occupancy;
   // this covers committed-but-undrained entries as well.
   for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_slot
      logic [c_IDX_W-1:0] w_off;
      assign w_off     = c_IDX_W'(gi) - r_head[c_IDX_W-1:0];
      assign w_hit[gi] = ({1'b0, w_off} < w_count) &&
                         (r_addr_mem[gi][31:2] == ld_addr[31:2]);
   end

   assign ld_conflict = |w_hit;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed self-checking bench for store_buffer (depth 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic        commit_store1_valid;
   logic        commit_store2_valid;
   logic [31:0] ld_addr;
   logic        ld_conflict;
   logic        data_req;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        sb_empty;

   int errors = 0;
   int checks = 0;

   store_buffer #(.SB_DEPTH(8)) dut (
      .clk                 (clk),
      .reset               (reset),
      .flush               (flush),
      .st_valid            (st_valid),
      .st_ready            (st_ready),
      .st_addr             (st_addr),
      .st_wstrb            (st_wstrb),
      .st_wdata            (st_wdata),
      .commit_store1_valid (commit_store1_valid),
      .commit_store2_valid (commit_store2_valid),
      .ld_addr             (ld_addr),
      .ld_conflict         (ld_conflict),
      .data_req            (data_req),
      .data_addr           (data_addr),
      .data_wstrb          (data_wstrb),
      .data_wdata          (data_wdata),
      .data_addr_ok        (data_addr_ok),
      .sb_empty            (sb_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus must never present commit2 without commit1.
   always @(negedge clk) begin
      if (!reset) begin
         assert (!(commit_store2_valid && !commit_store1_valid))
            else $error("illegal commit2 without commit1");
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] w_addr(input int k);
      return 32'h5000_0000 + 32'(k * 4);
   endfunction
   function automatic logic [31:0] w_data(input int k);
      return 32'hC3C3_0000 ^ (32'(k) * 32'h0101_0101);
   endfunction
   function automatic logic [3:0] w_strb(input int k);
      return 4'((k % 15) + 1);
   endfunction

   int sent, rx, m_unc, ncm;
   logic acc, drn, m_ready, m_req;

   initial begin
      reset = 1'b1; flush = 1'b0; st_valid = 1'b0; st_addr = '0; st_wstrb = '0;
      st_wdata = '0; commit_store1_valid = 1'b0; commit_store2_valid = 1'b0;
      ld_addr = '0; data_addr_ok = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
      #1;

      // ---------------- reset state ----------------
      chk("rst_empty",  32'(sb_empty), 32'd1);
      chk("rst_ready",  32'(st_ready), 32'd1);
      chk("rst_req",    32'(data_req), 32'd0);
      chk("rst_addr",   data_addr, 32'h0);
      chk("rst_wstrb",  32'(data_wstrb), 32'h0);
      chk("rst_wdata",  data_wdata, 32'h0);
      chk("rst_ldconf", 32'(ld_conflict), 32'd0);

      // ---------------- basic drain ----------------
      st_valid = 1'b1; st_addr = 32'h1000_0004; st_wdata = 32'hDEADBEEF; st_wstrb = 4'hF;
      cyc();
      st_valid = 1'b0;
      chk("basic_req_precommit", 32'(data_req), 32'd0);
      chk("basic_notempty",      32'(sb_empty), 32'd0);
      commit_store1_valid = 1'b1;
      cyc();
      commit_store1_valid = 1'b0;
      chk("basic_req",   32'(data_req), 32'd1);
      chk("basic_addr",  data_addr, 32'h1000_0004);
      chk("basic_wdata", data_wdata, 32'hDEADBEEF);
      chk("basic_wstrb", 32'(data_wstrb), 32'hF);
      data_addr_ok = 1'b1;
      cyc();
      data_addr_ok = 1'b0;
      chk("basic_empty_after", 32'(sb_empty), 32'd1);
      chk("basic_req_after",   32'(data_req), 32'd0);

      // ---------------- fill, dual commit, stall ----------------
      for (int i = 0; i < 8; i++) begin
         st_valid = 1'b1; st_addr = 32'h3000_0000 + 32'(i * 4);
         st_wdata = 32'hA000_0000 + 32'(i); st_wstrb = 4'hF;
         cyc();
      end
      st_valid = 1'b0;
      chk("fill_ready_full", 32'(st_ready), 32'd0);
      commit_store1_valid = 1'b1; commit_store2_valid = 1'b1;
      cyc();
      commit_store1_valid = 1'b0; commit_store2_valid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk("stall_req",   32'(data_req), 32'd1);
         chk("stall_addr",  data_addr, 32'h3000_0000);
         chk("stall_wdata", data_wdata, 32'hA000_0000);
         cyc();
      end
      data_addr_ok = 1'b1;
      #1;
      chk("full_drain_ready", 32'(st_ready), 32'd0);
      cyc();
      chk("drain1_ready", 32'(st_ready), 32'd1);
      chk("drain1_req",   32'(data_req), 32'd1);
      chk("drain1_addr",  data_addr, 32'h3000_0004);
      chk("drain1_wdata", data_wdata, 32'hA000_0001);
      cyc();
      data_addr_ok = 1'b0;
      chk("drain2_req", 32'(data_req), 32'd0);
      chk("drain2_nonempty", 32'(sb_empty), 32'd0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("fill_flush_empty", 32'(sb_empty), 32'd1);

      // ---------------- flush with commit in the same cycle ----------------
      for (int i = 0; i < 4; i++) begin
         st_valid = 1'b1; st_addr = 32'h4000_0000 + 32'(i * 4);
         st_wdata = 32'hB0 + 32'(i); st_wstrb = 4'h3;
         cyc();
      end
      st_valid = 1'b0;
      commit_store1_valid = 1'b1;
      cyc();
      flush = 1'b1; commit_store1_valid = 1'b1;
      st_valid = 1'b1; st_addr = 32'h4000_00F0; st_wdata = 32'hFF;
      cyc();
      flush = 1'b0; commit_store1_valid = 1'b0; st_valid = 1'b0;
      data_addr_ok = 1'b1;
      for (int j = 0; j < 2; j++) begin
         chk("flush_req",   32'(data_req), 32'd1);
         chk("flush_addr",  data_addr, 32'h4000_0000 + 32'(j * 4));
         chk("flush_wdata", data_wdata, 32'hB0 + 32'(j));
         cyc();
      end
      data_addr_ok = 1'b0;
      chk("flush_req_done", 32'(data_req), 32'd0);
      chk("flush_empty",    32'(sb_empty), 32'd1);

      // ---------------- load conflict ----------------
      st_valid = 1'b1; st_addr = 32'h2000_0008; st_wdata = 32'h55; st_wstrb = 4'h1;
      cyc();
      st_valid = 1'b0;
      ld_addr = 32'h2000_000B; #1;
      chk("ldc_same_word", 32'(ld_conflict), 32'd1);
      ld_addr = 32'h2000_000C; #1;
      chk("ldc_next_word", 32'(ld_conflict), 32'd0);
      commit_store1_valid = 1'b1;
      cyc();
      commit_store1_valid = 1'b0;
      ld_addr = 32'h2000_000B; #1;
      chk("ldc_committed", 32'(ld_conflict), 32'd1);
      data_addr_ok = 1'b1;
      cyc();
      data_addr_ok = 1'b0;
      #1;
      chk("ldc_drained", 32'(ld_conflict), 32'd0);
      chk("ldc_empty",   32'(sb_empty), 32'd1);
      ld_addr = '0;

      // ---------------- wrap-around stream ----------------
      sent = 0; rx = 0; m_unc = 0;
      for (int it = 0; it < 400 && !(sent == 20 && rx == 20); it++) begin
         st_valid = (sent < 20);
         st_addr = w_addr(sent); st_wdata = w_data(sent); st_wstrb = w_strb(sent);
         commit_store1_valid = (m_unc > 0) && ($urandom_range(0, 1) == 1);
         commit_store2_valid = commit_store1_valid && (m_unc > 1) && ($urandom_range(0, 1) == 1);
         data_addr_ok = ($urandom_range(0, 1) == 1);
         #1;
         m_ready = ((sent - rx) < 8);
         m_req   = ((sent - m_unc - rx) > 0);
         chk("wrap_ready", 32'(st_ready), 32'(m_ready));
         chk("wrap_req",   32'(data_req), 32'(m_req));
         drn = m_req && data_addr_ok;
         if (drn) begin
            chk("wrap_addr",  data_addr, w_addr(rx));
            chk("wrap_wdata", data_wdata, w_data(rx));
            chk("wrap_wstrb", 32'(data_wstrb), 32'(w_strb(rx)));
         end
         acc = st_valid && m_ready;
         ncm = int'(commit_store1_valid) + int'(commit_store2_valid);
         assert (ncm <= m_unc) else $error("commit count exceeds uncommitted");
         cyc();
         sent  += int'(acc);
         m_unc += int'(acc) - ncm;
         rx    += int'(drn);
      end
      st_valid = 1'b0; commit_store1_valid = 1'b0; commit_store2_valid = 1'b0;
      data_addr_ok = 1'b0;
      #1;
      chk("wrap_received", 32'(rx), 32'd20);
      chk("wrap_empty",    32'(sb_empty), 32'd1);

      // ---------------- reset mid-drain ----------------
      for (int i = 0; i < 3; i++) begin
         st_valid = 1'b1; st_addr = 32'h6000_0000 + 32'(i * 4);
         st_wdata = 32'h600 + 32'(i); st_wstrb = 4'hF;
         cyc();
      end
      st_valid = 1'b0;
      commit_store1_valid = 1'b1;
      cyc();
      commit_store1_valid = 1'b0;
      chk("rstmid_req_before", 32'(data_req), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("rstmid_req",   32'(data_req), 32'd0);
      chk("rstmid_empty", 32'(sb_empty), 32'd1);
      chk("rstmid_ready", 32'(st_ready), 32'd1);
      chk("rstmid_addr",  data_addr, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
